// File: rtl/shift_unit_arbiter_pkg.sv
// Shared encodings for the shift-unit arbiter: shift op codes and FSM states.
package shift_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/shift_rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr, wrapping NREQ-1 -> 0.
module shift_rr_arbiter
    import shift_unit_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            cand = sum[IDW-1:0];
            if (!any && valid[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one left/right shifter pair among NREQ requesters with round-robin grant.
// States:  IDLE | waiting for a request, grant driven combinationally
//          EXEC | one cycle with the selected shifter enabled, result captured at end
//          DONE | result held until the consumer accepts it
module shift_unit_arbiter
    import shift_unit_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   ReqValid,
    output logic [NREQ-1:0]   ReqReady,
    input  logic [2*NREQ-1:0] ReqOp,
    input  logic [32*NREQ-1:0] ReqA,
    input  logic [5*NREQ-1:0] ReqAmt,
    output logic [31:0]       ShIn1,
    output logic [31:0]       ShIn2,
    output logic              ShLEnable,
    output logic              ShREnable,
    output logic              ShArith,
    input  logic [31:0]       ShLOut,
    input  logic [31:0]       ShROut,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [31:0]       RespData,
    output logic [IDW-1:0]    RespId,
    output logic              RespErr
);

    arb_state_t      state, state_nx;
    shift_op_t       op_q;
    logic [IDW-1:0]  ptr_q, id_q, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            gnt_any, accept;
    logic [1:0]      sel_op;
    logic [31:0]     sel_a;
    logic [4:0]      sel_amt;

    shift_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .valid (ReqValid),
        .ptr   (ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    always_comb begin
        sel_op  = '0;
        sel_a   = '0;
        sel_amt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_op  = ReqOp[2*i +: 2];
                sel_a   = ReqA[32*i +: 32];
                sel_amt = ReqAmt[5*i +: 5];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Grant is suppressed while RST is high so every output reads zero during reset.
    always_comb begin
        state_nx  = state;
        ReqReady  = '0;
        ShLEnable = 1'b0;
        ShREnable = 1'b0;
        ShArith   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                ReqReady = RST ? '0 : gnt;
                accept   = gnt_any && !RST;
                if (accept) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                ShLEnable = (op_q == OP_SLL);
                ShREnable = (op_q == OP_SRL) || (op_q == OP_SRA);
                ShArith   = (op_q == OP_SRA);
                state_nx  = ST_DONE;
            end
            ST_DONE: begin
                if (RespReady) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q      <= OP_SLL;
            ptr_q     <= '0;
            id_q      <= '0;
            ShIn1     <= '0;
            ShIn2     <= '0;
            RespValid <= 1'b0;
            RespData  <= '0;
            RespId    <= '0;
            RespErr   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= shift_op_t'(sel_op);
                ShIn1 <= sel_a;
                ShIn2 <= {27'b0, sel_amt};
                id_q  <= gnt_idx;
                if (gnt_idx == IDW'(NREQ-1)) ptr_q <= '0;
                else                         ptr_q <= gnt_idx + 1'b1;
            end
            if (state == ST_EXEC) begin
                RespValid <= 1'b1;
                RespErr   <= (op_q == OP_ILL);
                RespId    <= id_q;
                case (op_q)
                    OP_SLL:         RespData <= ShLOut;
                    OP_SRL, OP_SRA: RespData <= ShROut;
                    default:        RespData <= '0;
                endcase
            end
            if (state == ST_DONE && RespReady) RespValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter with behavioural enable-gated shifters.
module tb_shift_unit_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              CLK;
    logic              RST;
    logic [NREQ-1:0]   ReqValid;
    logic [NREQ-1:0]   ReqReady;
    logic [2*NREQ-1:0] ReqOp;
    logic [32*NREQ-1:0] ReqA;
    logic [5*NREQ-1:0] ReqAmt;
    logic [31:0]       ShIn1, ShIn2;
    logic              ShLEnable, ShREnable, ShArith;
    logic [31:0]       ShLOut, ShROut;
    logic              RespValid, RespReady;
    logic [31:0]       RespData;
    logic [IDW-1:0]    RespId;
    logic              RespErr;

    int n_total = 0;
    int n_pass  = 0;

    logic        exec_len, exec_ren, exec_rv;
    logic [31:0] exec_in1, exec_in2;
    int          resp_wait;
    logic [31:0] cap_id [4];
    logic [31:0] cap_data [4];
    int          got;

    shift_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqOp     (ReqOp),
        .ReqA      (ReqA),
        .ReqAmt    (ReqAmt),
        .ShIn1     (ShIn1),
        .ShIn2     (ShIn2),
        .ShLEnable (ShLEnable),
        .ShREnable (ShREnable),
        .ShArith   (ShArith),
        .ShLOut    (ShLOut),
        .ShROut    (ShROut),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespData  (RespData),
        .RespId    (RespId),
        .RespErr   (RespErr)
    );

    // Shifters drive zero when not enabled.
    assign ShLOut = ShLEnable ? (ShIn1 << ShIn2[4:0]) : 32'h0;
    assign ShROut = ShREnable ? (ShArith ? 32'($signed(ShIn1) >>> ShIn2[4:0])
                                         : (ShIn1 >> ShIn2[4:0])) : 32'h0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
        ReqOp[2*r +: 2]   = op;
        ReqA[32*r +: 32]  = a;
        ReqAmt[5*r +: 5]  = amt;
    endtask

    // Starts at a negedge in IDLE; returns at the first negedge with RespValid high.
    task automatic issue(input int r, input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
        int n;
        set_req(r, op, a, amt);
        ReqValid[r] = 1'b1;
        #1;
        n = 0;
        while (!ReqReady[r] && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (!ReqReady[r]) begin
            n_total++;
            $error("FAIL grant_timeout: requester %0d never granted", r);
        end
        @(posedge CLK);
        @(negedge CLK);
        exec_len = ShLEnable;
        exec_ren = ShREnable;
        exec_rv  = RespValid;
        exec_in1 = ShIn1;
        exec_in2 = ShIn2;
        ReqValid[r] = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!RespValid && n < 10);
        resp_wait = n;
        if (!RespValid) begin
            n_total++;
            $error("FAIL resp_timeout: no RespValid for requester %0d", r);
        end
    endtask

    initial begin
        RST       = 1'b0;
        ReqValid  = '0;
        ReqOp     = '0;
        ReqA      = '0;
        ReqAmt    = '0;
        RespReady = 1'b1;
        #2 RST = 1'b1;
        ReqValid = 2'b11;
        @(negedge CLK);
        @(negedge CLK);

        // Reset state
        check("rst_reqready", 32'(ReqReady), 32'h0);
        check("rst_shin1", ShIn1, 32'h0);
        check("rst_shin2", ShIn2, 32'h0);
        check("rst_enables", {29'b0, ShLEnable, ShREnable, ShArith}, 32'h0);
        check("rst_resp", {29'b0, RespValid, RespErr, RespId}, 32'h0);
        check("rst_respdata", RespData, 32'h0);
        ReqValid = '0;
        RST = 1'b0;
        @(negedge CLK);

        // 1: SLL on requester 0
        issue(0, 2'b00, 32'h0000_0001, 5'd4);
        check("t1_exec_len", 32'(exec_len), 32'h1);
        check("t1_exec_ren", 32'(exec_ren), 32'h0);
        check("t1_exec_rv", 32'(exec_rv), 32'h0);
        check("t1_exec_in1", exec_in1, 32'h0000_0001);
        check("t1_exec_in2", exec_in2, 32'h0000_0004);
        check("t1_latency", 32'(resp_wait), 32'h1);
        check("t1_data", RespData, 32'h0000_0010);
        check("t1_id", 32'(RespId), 32'h0);
        check("t1_err", 32'(RespErr), 32'h0);
        check("t1_len_done", 32'(ShLEnable), 32'h0);
        @(negedge CLK);
        check("t1_released", 32'(RespValid), 32'h0);

        // 2: SRA and SRL on requester 1
        issue(1, 2'b10, 32'h8000_0000, 5'd31);
        check("t2_sra_exec_ren", 32'({exec_len, exec_ren}), 32'h1);
        check("t2_sra_data", RespData, 32'hFFFF_FFFF);
        check("t2_sra_id", 32'(RespId), 32'h1);
        @(negedge CLK);
        issue(1, 2'b01, 32'h8000_0000, 5'd31);
        check("t2_srl_data", RespData, 32'h0000_0001);
        check("t2_srl_err", 32'(RespErr), 32'h0);
        @(negedge CLK);

        // 3: both requesters held valid, round-robin alternation
        set_req(0, 2'b00, 32'h0000_0003, 5'd1);
        set_req(1, 2'b01, 32'h0000_0100, 5'd4);
        ReqValid = 2'b11;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge CLK);
            if (RespValid) begin
                cap_id[got]   = 32'(RespId);
                cap_data[got] = RespData;
                got++;
                if (got == 4) ReqValid = '0;
            end
        end
        check("t3_count", 32'(got), 32'd4);
        check("t3_id0", cap_id[0], 32'h0);
        check("t3_id1", cap_id[1], 32'h1);
        check("t3_id2", cap_id[2], 32'h0);
        check("t3_id3", cap_id[3], 32'h1);
        check("t3_data0", cap_data[0], 32'h0000_0006);
        check("t3_data1", cap_data[1], 32'h0000_0010);
        @(negedge CLK);

        // 4: consumer stalls for 5 cycles
        RespReady = 1'b0;
        issue(0, 2'b00, 32'h0000_000F, 5'd8);
        ReqValid = 2'b11;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", 32'(RespValid), 32'h1);
            check("t4_hold_data", RespData, 32'h0000_0F00);
            check("t4_hold_id", 32'(RespId), 32'h0);
            check("t4_hold_reqready", 32'(ReqReady), 32'h0);
            @(negedge CLK);
        end
        ReqValid  = '0;
        RespReady = 1'b1;
        @(negedge CLK);
        check("t4_accepted", 32'(RespValid), 32'h0);

        // 5: illegal op on requester 1
        issue(1, 2'b11, 32'hDEAD_BEEF, 5'd5);
        check("t5_no_enable", 32'({exec_len, exec_ren}), 32'h0);
        check("t5_err", 32'(RespErr), 32'h1);
        check("t5_data", RespData, 32'h0);
        check("t5_id", 32'(RespId), 32'h1);
        @(negedge CLK);

        // 6: reset during EXEC
        issue(0, 2'b00, 32'h0000_0001, 5'd1);
        @(negedge CLK);
        set_req(1, 2'b10, 32'h8000_0000, 5'd3);
        ReqValid = 2'b10;
        #1;
        check("t6_grant1", 32'(ReqReady), 32'h2);
        @(posedge CLK);
        @(negedge CLK);
        check("t6_in_exec", 32'(ShREnable), 32'h1);
        RST = 1'b1;
        ReqValid = 2'b11;
        #1;
        check("t6_rst_reqready", 32'(ReqReady), 32'h0);
        check("t6_rst_enables", {29'b0, ShLEnable, ShREnable, ShArith}, 32'h0);
        check("t6_rst_shin", ShIn1 | ShIn2, 32'h0);
        check("t6_rst_resp", {29'b0, RespValid, RespErr, RespId}, 32'h0);
        @(negedge CLK);
        ReqValid = '0;
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("t6_no_resp", 32'(RespValid), 32'h0);
        end
        ReqValid = 2'b11;
        #1;
        check("t6_grant_after_rst", 32'(ReqReady), 32'h1);
        ReqValid = '0;
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
